// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bg_pkg
// Brief    : Colours, door/handle geometry and screen size for the background.
// Revision : 1.0
// ============================================================================
package bg_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  localparam logic [11:0] BLANK_RGB  = 12'h000;
  localparam logic [11:0] VIOLET_RGB = 12'h82C;
  localparam logic [11:0] BROWN_RGB  = 12'h530;
  localparam logic [11:0] DOOR_RGB   = 12'h500;
  localparam logic [11:0] BORDER_RGB = 12'hFF0;
  localparam logic [11:0] FILL_RGB   = 12'h888;

  // Half-open rectangles [X0,X1) x [Y0,Y1)
  localparam int HANDLE_X0 = 720;
  localparam int HANDLE_X1 = 730;
  localparam int HANDLE_Y0 = 310;
  localparam int HANDLE_Y1 = 320;
  localparam int FRAME_X0  = 710;
  localparam int FRAME_X1  = 790;
  localparam int FRAME_Y0  = 250;
  localparam int FRAME_Y1  = 390;
  localparam int BODY_X0   = 700;
  localparam int BODY_X1   = 780;
  localparam int BODY_Y0   = 240;
  localparam int BODY_Y1   = 380;

  typedef struct packed {
    logic blank;
    logic handle;
    logic door_frame;
    logic door_body;
    logic border;
  } region_t;

  function automatic logic in_rect(input logic [10:0] h, input logic [10:0] v,
                                   input int x0, input int x1,
                                   input int y0, input int y1);
    return (int'(h) >= x0) && (int'(h) < x1) && (int'(v) >= y0) && (int'(v) < y1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obst_hit.sv
`default_nettype none
// ============================================================================
// Module   : obst_hit
// Brief    : Combinational test of one obstacle square against a pixel.
// Revision : 1.0
// ============================================================================
module obst_hit #(
  parameter int CELL    = 100,
  parameter int COORD_W = 3
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_en,
  input  logic [10:0]        i_hcount,
  input  logic [10:0]        i_vcount,
  output logic               o_hit
);

  logic [31:0] w_bx;
  logic [31:0] w_by;
  logic [31:0] w_h;
  logic [31:0] w_v;

  // Wide arithmetic so the square's far edge never wraps.
  assign w_bx = 32'(i_x) * 32'(CELL);
  assign w_by = 32'(i_y) * 32'(CELL);
  assign w_h  = 32'(i_hcount);
  assign w_v  = 32'(i_vcount);

  assign o_hit = i_en
              && (w_h >= w_bx) && (w_h < w_bx + 32'(CELL))
              && (w_v >= w_by) && (w_v < w_by + 32'(CELL));

endmodule
`default_nettype wire

// File: rtl/draw_background_grid.sv
`default_nettype none
// ============================================================================
// Module   : draw_background_grid
// Brief    : Background layer with runtime obstacle map committed per frame.
// Revision : 1.0
// ============================================================================
module draw_background_grid
  import bg_pkg::*;
#(
  parameter int                          N_OBST       = 8,
  parameter int                          CELL         = 100,
  parameter int                          COORD_W      = 3,
  parameter int                          BLINK_FRAMES = 30,
  parameter int                          IDX_W        = (N_OBST < 2) ? 1 : $clog2(N_OBST),
  parameter logic [N_OBST*2*COORD_W-1:0] INIT_XY      = {6'o10, 6'o21, 6'o32, 30'd0},
  parameter logic [N_OBST-1:0]           INIT_EN      = 8'b1110_0000
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic [10:0]                   hcount_in,
  input  logic [10:0]                   vcount_in,
  input  logic                          hsync_in,
  input  logic                          hblank_in,
  input  logic                          vsync_in,
  input  logic                          vblank_in,
  input  logic                          obst_wr_valid,
  output logic                          obst_wr_ready,
  input  logic [IDX_W-1:0]              obst_wr_idx,
  input  logic [COORD_W-1:0]            obst_wr_x,
  input  logic [COORD_W-1:0]            obst_wr_y,
  input  logic                          obst_wr_en,
  input  logic                          commit_req,
  output logic [10:0]                   hcount_out,
  output logic [10:0]                   vcount_out,
  output logic                          hsync_out,
  output logic                          hblank_out,
  output logic                          vsync_out,
  output logic                          vblank_out,
  output logic [11:0]                   rgb_out,
  output logic [N_OBST*2*COORD_W-1:0]   st_obst_xy,
  output logic [N_OBST-1:0]             st_obst_en
);

  localparam int SLOT_W = 2 * COORD_W;
  localparam int MAP_W  = N_OBST * SLOT_W;

  logic [MAP_W-1:0]  r_sh_xy;
  logic [N_OBST-1:0] r_sh_en;
  logic [MAP_W-1:0]  r_act_xy;
  logic [N_OBST-1:0] r_act_en;
  logic [MAP_W-1:0]  r_st_xy;
  logic [N_OBST-1:0] r_st_en;
  logic              r_commit_pending;
  logic              r_vblank_q;
  logic [7:0]        r_frame_cnt;
  logic              r_handle_on;

  logic              w_frame_start;
  logic              w_wr_fire;
  logic [N_OBST-1:0] w_hit;
  region_t           w_region;
  logic [11:0]       w_rgb;

  logic [N_OBST-1:0] r_s1_hit;
  region_t           r_s1_region;
  logic              r_s1_handle_on;
  logic [10:0]       r_s1_hcount;
  logic [10:0]       r_s1_vcount;
  logic              r_s1_hsync;
  logic              r_s1_hblank;
  logic              r_s1_vsync;
  logic              r_s1_vblank;

  assign obst_wr_ready = !r_commit_pending;
  assign w_wr_fire     = obst_wr_valid && obst_wr_ready;
  assign w_frame_start = vblank_in && !r_vblank_q;
  assign st_obst_xy    = r_st_xy;
  assign st_obst_en    = r_st_en;

  // Shadow/active maps and commit handshake; slot i lives at the MSB end.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_sh_xy          <= INIT_XY;
      r_sh_en          <= INIT_EN;
      r_act_xy         <= INIT_XY;
      r_act_en         <= INIT_EN;
      r_st_xy          <= INIT_XY;
      r_st_en          <= INIT_EN;
      r_commit_pending <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        for (int i = 0; i < N_OBST; i++) begin
          if (obst_wr_idx == IDX_W'(i)) begin
            r_sh_xy[(N_OBST-1-i)*SLOT_W +: SLOT_W] <= {obst_wr_x, obst_wr_y};
            r_sh_en[N_OBST-1-i]                    <= obst_wr_en;
          end
        end
      end
      if (w_frame_start && r_commit_pending) begin
        r_act_xy         <= r_sh_xy;
        r_act_en         <= r_sh_en;
        r_commit_pending <= 1'b0;
      end else if (commit_req) begin
        r_commit_pending <= 1'b1;
      end
      r_st_xy <= r_act_xy;
      r_st_en <= r_act_en;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vblank_q  <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_handle_on <= 1'b1;
    end else begin
      r_vblank_q <= vblank_in;
      if (w_frame_start) begin
        if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= 8'd0;
          r_handle_on <= ~r_handle_on;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_OBST; g++) begin : g_slot
    obst_hit #(
      .CELL    (CELL),
      .COORD_W (COORD_W)
    ) u_hit (
      .i_x      (r_act_xy[(N_OBST-1-g)*SLOT_W + COORD_W +: COORD_W]),
      .i_y      (r_act_xy[(N_OBST-1-g)*SLOT_W +: COORD_W]),
      .i_en     (r_act_en[N_OBST-1-g]),
      .i_hcount (hcount_in),
      .i_vcount (vcount_in),
      .o_hit    (w_hit[g])
    );
  end

  always_comb begin
    w_region            = '0;
    w_region.blank      = hblank_in || vblank_in;
    w_region.handle     = in_rect(hcount_in, vcount_in, HANDLE_X0, HANDLE_X1, HANDLE_Y0, HANDLE_Y1);
    w_region.door_frame = in_rect(hcount_in, vcount_in, FRAME_X0, FRAME_X1, FRAME_Y0, FRAME_Y1);
    w_region.door_body  = in_rect(hcount_in, vcount_in, BODY_X0, BODY_X1, BODY_Y0, BODY_Y1);
    w_region.border     = (hcount_in == 11'd0) || (int'(hcount_in) == H_ACTIVE - 1)
                       || (vcount_in == 11'd0) || (int'(vcount_in) == V_ACTIVE - 1);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_s1_hit       <= '0;
      r_s1_region    <= '0;
      r_s1_handle_on <= 1'b0;
      r_s1_hcount    <= 11'd0;
      r_s1_vcount    <= 11'd0;
      r_s1_hsync     <= 1'b0;
      r_s1_hblank    <= 1'b0;
      r_s1_vsync     <= 1'b0;
      r_s1_vblank    <= 1'b0;
    end else begin
      r_s1_hit       <= w_hit;
      r_s1_region    <= w_region;
      r_s1_handle_on <= r_handle_on;
      r_s1_hcount    <= hcount_in;
      r_s1_vcount    <= vcount_in;
      r_s1_hsync     <= hsync_in;
      r_s1_hblank    <= hblank_in;
      r_s1_vsync     <= vsync_in;
      r_s1_vblank    <= vblank_in;
    end
  end

  always_comb begin
    w_rgb = FILL_RGB;
    if (r_s1_region.blank)           w_rgb = BLANK_RGB;
    else if (|r_s1_hit)              w_rgb = VIOLET_RGB;
    else if (r_s1_region.handle)     w_rgb = r_s1_handle_on ? DOOR_RGB : BROWN_RGB;
    else if (r_s1_region.door_frame) w_rgb = BROWN_RGB;
    else if (r_s1_region.door_body)  w_rgb = DOOR_RGB;
    else if (r_s1_region.border)     w_rgb = BORDER_RGB;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_out    <= 12'h000;
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblank_out <= 1'b0;
      vsync_out  <= 1'b0;
      vblank_out <= 1'b0;
    end else begin
      rgb_out    <= w_rgb;
      hcount_out <= r_s1_hcount;
      vcount_out <= r_s1_vcount;
      hsync_out  <= r_s1_hsync;
      hblank_out <= r_s1_hblank;
      vsync_out  <= r_s1_vsync;
      vblank_out <= r_s1_vblank;
    end
  end

endmodule
`default_nettype wire
